// File: rtl/mdu_issue.sv
`default_nettype none
// ============================================================================
// Module      : mdu_issue
// Description : Issue and interlock control between the E stage and a
//               multi-cycle multiply/divide unit (MDU).
//               - Arbitrates the E-stage request fields. Arithmetic ops win
//                 over move-to, and move-to wins over move-from.
//               - Stalls the pipeline while an MDU op is in flight.
//               - Drives the op code and the move-to strobe to the MDU.
//               - Returns HI/LO for move-from requests.
//               - Flags MDU latency overruns and illegal op codes through a
//                 sticky error bit.
//               - Counts accepted arithmetic ops.
//
// Ports       : clk, reset            - clock, synchronous active-high reset
//               E_MDUStart/E_MDUOp    - E-stage arithmetic request, op code
//               E_MTHILO/E_MFHILO     - E-stage move-to / move-from requests
//               E_SrcA/E_SrcB         - E-stage operands (passed to the MDU)
//               E_Flush               - E-stage instruction squashed
//               MDU_Busy/HI/LO        - MDU status and result registers
//               MDU_Op/MDU_MTHILO     - commands driven to the MDU
//               MDU_SrcA/MDU_SrcB     - operands driven to the MDU
//               Stall                 - freeze the pipeline at E
//               E_MDUData             - HI/LO data for an accepted move-from
//               TimeoutErr            - sticky error flag
//               OpCount               - accepted arithmetic op counter
//
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_issue #(
    parameter int MULT_CYCLES   = 5,
    parameter int DIV_CYCLES    = 10,
    parameter int TIMEOUT_SLACK = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_MDUStart,
    input  logic [3:0]  E_MDUOp,
    input  logic [1:0]  E_MTHILO,
    input  logic [1:0]  E_MFHILO,
    input  logic [31:0] E_SrcA,
    input  logic [31:0] E_SrcB,
    input  logic        E_Flush,
    input  logic        MDU_Busy,
    input  logic [31:0] MDU_HI,
    input  logic [31:0] MDU_LO,
    output logic [3:0]  MDU_Op,
    output logic [1:0]  MDU_MTHILO,
    output logic [31:0] MDU_SrcA,
    output logic [31:0] MDU_SrcB,
    output logic        Stall,
    output logic [31:0] E_MDUData,
    output logic        TimeoutErr,
    output logic [15:0] OpCount
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    localparam logic [3:0] c_OP_IDLE = 4'b1111;
    localparam logic [1:0] c_MT_IDLE = 2'b00;
    localparam logic [1:0] c_MF_LO   = 2'b01;
    localparam logic [1:0] c_MF_HI   = 2'b11;

    // The latency budget includes the slack: the counter reaching zero
    // while the MDU still reports busy means the op overran.
    localparam int c_MULT_LAT = MULT_CYCLES + TIMEOUT_SLACK;
    localparam int c_DIV_LAT  = DIV_CYCLES + TIMEOUT_SLACK;
    localparam int c_MAX_LAT  = (c_MULT_LAT > c_DIV_LAT) ? c_MULT_LAT : c_DIV_LAT;
    localparam int c_CNT_W    = (c_MAX_LAT < 2) ? 1 : $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(c_MULT_LAT);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(c_DIV_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic               r_first;        // first WAIT cycle: MDU_Busy not yet valid
    logic [c_CNT_W-1:0] r_cnt;          // remaining latency budget
    logic [15:0]        r_opcount;
    logic               r_err;

    // ------------------------------------------------------------------
    // Request decode and arbitration
    // ------------------------------------------------------------------
    logic               w_req;
    logic               w_stall;
    logic               w_accept;
    logic               w_acc_arith;
    logic               w_acc_mt;
    logic               w_acc_mf;
    logic               w_op_legal;
    logic               w_issue;
    logic               w_illegal;
    logic               w_is_div;
    logic               w_timeout;
    logic [c_CNT_W-1:0] w_lat_load;

    // Reset is folded into the request so every combinational output
    // falls back to its idle value while reset is held.
    assign w_req = ~reset & ~E_Flush & (E_MDUStart | E_MTHILO[0] | E_MFHILO[0]);

    // While in WAIT the stall holds even in the cycle the MDU goes idle.
    // The request is then accepted one cycle later, from IDLE.
    assign w_stall  = w_req & ((r_state == c_ST_WAIT) | MDU_Busy);
    assign w_accept = w_req & ~w_stall;

    // Fixed priority: arithmetic > move-to > move-from.
    assign w_acc_arith = w_accept & E_MDUStart;
    assign w_acc_mt    = w_accept & ~E_MDUStart & E_MTHILO[0];
    assign w_acc_mf    = w_accept & ~E_MDUStart & ~E_MTHILO[0] & E_MFHILO[0];

    assign w_op_legal = ~E_MDUOp[3];
    assign w_issue    = w_acc_arith & w_op_legal;
    assign w_illegal  = w_acc_arith & ~w_op_legal;

    // Op codes 2 and 3 are the divide class.
    assign w_is_div   = (E_MDUOp[3:1] == 3'b001);
    assign w_lat_load = w_is_div ? c_DIV_LOAD : c_MULT_LOAD;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_issue) begin
                    w_state_next = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (!r_first && !MDU_Busy) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt <= c_CNT_ONE) begin
                    // Budget runs out at this edge. If the MDU is still
                    // busy, that is an overrun. The block leaves WAIT in
                    // either case so the pipeline cannot lock up.
                    w_state_next = c_ST_IDLE;
                    w_timeout    = MDU_Busy;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        MDU_Op     = c_OP_IDLE;
        MDU_MTHILO = c_MT_IDLE;
        E_MDUData  = 32'd0;
        Stall      = w_stall;
        if (w_issue) begin
            MDU_Op = E_MDUOp;
        end
        if (w_acc_mt) begin
            MDU_MTHILO = E_MTHILO;
        end
        if (w_acc_mf) begin
            if (E_MFHILO == c_MF_HI) begin
                E_MDUData = MDU_HI;
            end else if (E_MFHILO == c_MF_LO) begin
                E_MDUData = MDU_LO;
            end
        end
    end

    // ------------------------------------------------------------------
    // Latency counter and first-cycle marker
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= c_CNT_ZERO;
            r_first <= 1'b0;
        end else begin
            r_first <= w_issue;
            if (w_issue) begin
                r_cnt <= w_lat_load;
            end else if (r_state == c_ST_WAIT) begin
                if (w_state_next == c_ST_IDLE) begin
                    r_cnt <= c_CNT_ZERO;
                end else if (r_cnt != c_CNT_ZERO) begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Op counter and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcount <= 16'd0;
            r_err     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_opcount <= r_opcount + 16'd1;
            end
            if (w_timeout || w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign MDU_SrcA   = E_SrcA;
    assign MDU_SrcB   = E_SrcB;
    assign TimeoutErr = r_err;
    assign OpCount    = r_opcount;

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_issue
// Description : Directed bench for mdu_issue. The bench includes a small
//               behavioural MDU. That MDU latches an op at the issue edge.
//               It raises busy from the second cycle after issue. It holds
//               busy for (CYCLES - 2) cycles. A force input can pin busy
//               high to provoke an overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_issue;

    localparam int MULT_CYCLES   = 5;
    localparam int DIV_CYCLES    = 10;
    localparam int TIMEOUT_SLACK = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_MDUStart;
    logic [3:0]  E_MDUOp;
    logic [1:0]  E_MTHILO;
    logic [1:0]  E_MFHILO;
    logic [31:0] E_SrcA;
    logic [31:0] E_SrcB;
    logic        E_Flush;
    logic        MDU_Busy;
    logic [31:0] MDU_HI;
    logic [31:0] MDU_LO;
    logic [3:0]  MDU_Op;
    logic [1:0]  MDU_MTHILO;
    logic [31:0] MDU_SrcA;
    logic [31:0] MDU_SrcB;
    logic        Stall;
    logic [31:0] E_MDUData;
    logic        TimeoutErr;
    logic [15:0] OpCount;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_stall;

    always #5 clk = ~clk;

    mdu_issue #(
        .MULT_CYCLES   (MULT_CYCLES),
        .DIV_CYCLES    (DIV_CYCLES),
        .TIMEOUT_SLACK (TIMEOUT_SLACK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDUStart (E_MDUStart),
        .E_MDUOp    (E_MDUOp),
        .E_MTHILO   (E_MTHILO),
        .E_MFHILO   (E_MFHILO),
        .E_SrcA     (E_SrcA),
        .E_SrcB     (E_SrcB),
        .E_Flush    (E_Flush),
        .MDU_Busy   (MDU_Busy),
        .MDU_HI     (MDU_HI),
        .MDU_LO     (MDU_LO),
        .MDU_Op     (MDU_Op),
        .MDU_MTHILO (MDU_MTHILO),
        .MDU_SrcA   (MDU_SrcA),
        .MDU_SrcB   (MDU_SrcB),
        .Stall      (Stall),
        .E_MDUData  (E_MDUData),
        .TimeoutErr (TimeoutErr),
        .OpCount    (OpCount)
    );

    // ------------------------------------------------------------------
    // Behavioural MDU
    // ------------------------------------------------------------------
    logic        m_arm;
    int          m_cnt;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        force_busy;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_prod_s = $signed({{32{MDU_SrcA[31]}}, MDU_SrcA}) * $signed({{32{MDU_SrcB[31]}}, MDU_SrcB});
    assign w_prod_u = {32'd0, MDU_SrcA} * {32'd0, MDU_SrcB};

    assign MDU_Busy = (~m_arm & (m_cnt != 0)) | force_busy;
    assign MDU_HI   = m_hi;
    assign MDU_LO   = m_lo;

    always @(posedge clk) begin
        if (reset) begin
            m_arm <= 1'b0;
            m_cnt <= 0;
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
        end else begin
            if (MDU_Op != 4'hF) begin
                m_arm <= 1'b1;
                m_cnt <= (MDU_Op[3:1] == 3'b001) ? DIV_CYCLES - 2 : MULT_CYCLES - 2;
                case (MDU_Op)
                    4'd1: begin
                        m_hi <= w_prod_u[63:32];
                        m_lo <= w_prod_u[31:0];
                    end
                    4'd2: begin
                        m_hi <= (MDU_SrcB != 0) ? MDU_SrcA % MDU_SrcB : 32'd0;
                        m_lo <= (MDU_SrcB != 0) ? MDU_SrcA / MDU_SrcB : 32'd0;
                    end
                    4'd3: begin
                        m_hi <= (MDU_SrcB != 0) ? 32'($signed(MDU_SrcA) % $signed(MDU_SrcB)) : 32'd0;
                        m_lo <= (MDU_SrcB != 0) ? 32'($signed(MDU_SrcA) / $signed(MDU_SrcB)) : 32'd0;
                    end
                    default: begin
                        m_hi <= w_prod_s[63:32];
                        m_lo <= w_prod_s[31:0];
                    end
                endcase
            end else if (m_arm) begin
                m_arm <= 1'b0;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
            if (MDU_MTHILO == 2'b11) begin
                m_hi <= MDU_SrcA;
            end else if (MDU_MTHILO == 2'b01) begin
                m_lo <= MDU_SrcA;
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        E_MDUStart = 1'b0;
        E_MDUOp    = 4'd0;
        E_MTHILO   = 2'b00;
        E_MFHILO   = 2'b00;
        E_SrcA     = 32'd0;
        E_SrcB     = 32'd0;
        E_Flush    = 1'b0;
    endtask

    // Counts consecutive stalled cycles with the current inputs held.
    task automatic count_stalls(output int n);
        n = 0;
        #1;
        while (Stall === 1'b1 && n < 40) begin
            n++;
            tick();
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset      = 1'b1;
        force_busy = 1'b0;
        idle_in();
        tick();
        tick();

        // Reset: outputs idle even with a request present
        E_MDUStart = 1'b1; E_MDUOp = 4'd1; E_MFHILO = 2'b11;
        settle();
        check("rst_op",     MDU_Op,     4'hF);
        check("rst_stall",  Stall,      1'b0);
        check("rst_mthilo", MDU_MTHILO, 2'b00);
        check("rst_data",   E_MDUData,  32'd0);
        check("rst_cnt",    OpCount,    16'd0);
        check("rst_err",    TimeoutErr, 1'b0);
        idle_in();
        tick();
        reset = 1'b0;
        tick();

        // mult -3 * 7 then mflo
        E_MDUStart = 1'b1; E_MDUOp = 4'd1; E_SrcA = 32'hFFFF_FFFD; E_SrcB = 32'd7;
        settle();
        check("mult_op",    MDU_Op,   4'd1);
        check("mult_stall", Stall,    1'b0);
        check("mult_srca",  MDU_SrcA, 32'hFFFF_FFFD);
        check("mult_srcb",  MDU_SrcB, 32'd7);
        tick();
        idle_in(); E_MFHILO = 2'b01;
        settle();
        check("mult_opcnt", OpCount, 16'd1);
        check("mult_op_off", MDU_Op, 4'hF);
        count_stalls(n_stall);
        check("mflo_stalls", n_stall,   32'd5);
        check("mflo_data",   E_MDUData, 32'hFFFF_FFEB);
        tick();
        idle_in();

        // divu 100 / 7 then mfhi
        E_MDUStart = 1'b1; E_MDUOp = 4'd2; E_SrcA = 32'd100; E_SrcB = 32'd7;
        settle();
        check("divu_op", MDU_Op, 4'd2);
        tick();
        idle_in(); E_MFHILO = 2'b11;
        count_stalls(n_stall);
        check("mfhi_stalls", n_stall,   32'd10);
        check("mfhi_data",   E_MDUData, 32'd2);
        check("divu_opcnt",  OpCount,   16'd2);
        tick();
        idle_in();

        // Flush during WAIT releases the stall but does not abort WAIT
        E_MDUStart = 1'b1; E_MDUOp = 4'd2; E_SrcA = 32'd50; E_SrcB = 32'd8;
        tick();
        idle_in(); E_Flush = 1'b1; E_MFHILO = 2'b01;
        settle();
        check("flushw_stall", Stall,     1'b0);
        check("flushw_data",  E_MDUData, 32'd0);
        tick();
        E_Flush = 1'b0;
        settle();
        check("flushw_kept", Stall, 1'b1);
        count_stalls(n_stall);
        check("flushw_stalls", n_stall,   32'd9);
        check("flushw_data2",  E_MDUData, 32'd6);
        tick();
        idle_in();

        // mthi then mfhi
        E_MTHILO = 2'b11; E_SrcA = 32'h1234;
        settle();
        check("mthi_strobe", MDU_MTHILO, 2'b11);
        check("mthi_stall",  Stall,      1'b0);
        check("mthi_op",     MDU_Op,     4'hF);
        tick();
        idle_in(); E_MFHILO = 2'b11;
        settle();
        check("mthi_off",  MDU_MTHILO, 2'b00);
        check("mfhi_1234", E_MDUData,  32'h1234);
        tick();
        idle_in();

        // Move-to outranks move-from
        E_MTHILO = 2'b01; E_MFHILO = 2'b11; E_SrcA = 32'd55;
        settle();
        check("prio_mt",   MDU_MTHILO, 2'b01);
        check("prio_data", E_MDUData,  32'd0);
        tick();
        idle_in();

        // Flush together with an arithmetic start
        E_Flush = 1'b1; E_MDUStart = 1'b1; E_MDUOp = 4'd1;
        settle();
        check("flush_op",    MDU_Op, 4'hF);
        check("flush_stall", Stall,  1'b0);
        tick();
        idle_in();
        settle();
        check("flush_opcnt", OpCount, 16'd3);

        // Timeout: mult (arith outranks the simultaneous mthi), busy pinned high
        E_MDUStart = 1'b1; E_MDUOp = 4'd0; E_MTHILO = 2'b11; E_SrcA = 32'd2; E_SrcB = 32'd3;
        settle();
        check("to_op",     MDU_Op,     4'd0);
        check("to_mthilo", MDU_MTHILO, 2'b00);
        tick();
        idle_in();
        force_busy = 1'b1;
        settle();
        check("to_opcnt", OpCount, 16'd4);
        repeat (7) tick();
        check("to_err_pre", TimeoutErr, 1'b0);
        tick();
        check("to_err", TimeoutErr, 1'b1);
        force_busy = 1'b0;
        E_MTHILO = 2'b01; E_SrcA = 32'd5;
        settle();
        check("to_idle_stall", Stall,      1'b0);
        check("to_idle_mt",    MDU_MTHILO, 2'b01);
        tick();
        idle_in();

        // Sticky error only cleared by reset; illegal op sets it
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("clr_err",   TimeoutErr, 1'b0);
        check("clr_opcnt", OpCount,    16'd0);
        E_MDUStart = 1'b1; E_MDUOp = 4'hA;
        settle();
        check("ill_op",    MDU_Op, 4'hF);
        check("ill_stall", Stall,  1'b0);
        tick();
        idle_in(); E_MFHILO = 2'b01;
        settle();
        check("ill_err",   TimeoutErr, 1'b1);
        check("ill_opcnt", OpCount,    16'd0);
        check("ill_idle",  Stall,      1'b0);
        tick();
        idle_in();

        // Reset three cycles into a div
        E_MDUStart = 1'b1; E_MDUOp = 4'd2; E_SrcA = 32'd9; E_SrcB = 32'd2;
        tick();
        idle_in(); E_MFHILO = 2'b11;
        tick();
        tick();
        settle();
        check("rdiv_stall", Stall, 1'b1);
        reset = 1'b1;
        settle();
        check("rdiv_rst_stall", Stall,     1'b0);
        check("rdiv_rst_data",  E_MDUData, 32'd0);
        tick();
        reset = 1'b0;
        idle_in();
        E_MDUStart = 1'b1; E_MDUOp = 4'd1; E_SrcA = 32'd4; E_SrcB = 32'd5;
        settle();
        check("post_stall", Stall,   1'b0);
        check("post_opcnt", OpCount, 16'd0);
        check("post_op",    MDU_Op,  4'd1);
        check("post_err",   TimeoutErr, 1'b0);
        tick();
        idle_in(); E_MFHILO = 2'b01;
        settle();
        check("post_opcnt1", OpCount, 16'd1);
        count_stalls(n_stall);
        check("post_stalls", n_stall,   32'd5);
        check("post_data",   E_MDUData, 32'd20);
        tick();
        idle_in();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
